// File: rtl/axi4_region_decoder_if.sv
// One decode channel: request in, registered result out.
// Signals: in_valid/ready, addr, prot, master; out_valid/ready, slave, err.
interface axi4_region_decoder_if #(
  parameter int ADDR_WIDTH = 40,
  parameter int NUM_SLAVES = 8,
  parameter int MW         = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [2:0]            in_prot;
  logic [MW-1:0]         in_master;
  logic                  out_valid;
  logic                  out_ready;
  logic [NUM_SLAVES-1:0] out_slave;
  logic [1:0]            out_err;

  modport master (
    output in_valid, in_addr, in_prot, in_master, out_ready,
    input  in_ready, out_valid, out_slave, out_err
  );

  modport slave (
    input  in_valid, in_addr, in_prot, in_master, out_ready,
    output in_ready, out_valid, out_slave, out_err
  );
endinterface

// File: rtl/axi4_region_decoder.sv
// Registered AW/AR region decoder with programmable table and error status.
// Ports: aclk/areset, aw/ar channel interfaces, cfg_* table write, err_* status.
module axi4_region_decoder #(
  parameter  int ADDR_WIDTH  = 40,
  parameter  int NUM_SLAVES  = 8,
  parameter  int NUM_MASTERS = 8,
  parameter  int NUM_REGIONS = 8,
  localparam int SW = $clog2(NUM_SLAVES),
  localparam int MW = $clog2(NUM_MASTERS),
  localparam int RW = $clog2(NUM_REGIONS)
) (
  input  logic                   aclk,
  input  logic                   areset,
  axi4_region_decoder_if.slave   aw,
  axi4_region_decoder_if.slave   ar,
  input  logic                   cfg_we,
  input  logic [RW-1:0]          cfg_idx,
  input  logic [ADDR_WIDTH-1:0]  cfg_base,
  input  logic [ADDR_WIDTH-1:0]  cfg_limit,
  input  logic [SW-1:0]          cfg_slave,
  input  logic [NUM_MASTERS-1:0] cfg_mmask,
  input  logic [2:0]             cfg_prot_mask,
  input  logic [2:0]             cfg_prot_val,
  input  logic                   cfg_en,
  input  logic                   cfg_lock,
  output logic                   locked,
  input  logic                   err_clear,
  output logic                   err_valid,
  output logic [ADDR_WIDTH-1:0]  err_addr,
  output logic [MW-1:0]          err_master,
  output logic [1:0]             err_code,
  output logic                   err_is_write,
  output logic [15:0]            err_count
);

  // Region table
  logic                   en_q    [NUM_REGIONS];
  logic                   en_d    [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]  base_q  [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]  base_d  [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]  limit_q [NUM_REGIONS];
  logic [ADDR_WIDTH-1:0]  limit_d [NUM_REGIONS];
  logic [SW-1:0]          slv_q   [NUM_REGIONS];
  logic [SW-1:0]          slv_d   [NUM_REGIONS];
  logic [NUM_MASTERS-1:0] mmask_q [NUM_REGIONS];
  logic [NUM_MASTERS-1:0] mmask_d [NUM_REGIONS];
  logic [2:0]             pmask_q [NUM_REGIONS];
  logic [2:0]             pmask_d [NUM_REGIONS];
  logic [2:0]             pval_q  [NUM_REGIONS];
  logic [2:0]             pval_d  [NUM_REGIONS];
  logic                   locked_q, locked_d;

  // Channel 0 is AW, channel 1 is AR
  logic [ADDR_WIDTH-1:0]  c_addr   [2];
  logic [2:0]             c_prot   [2];
  logic [MW-1:0]          c_mst    [2];
  logic                   c_ivld   [2];
  logic                   c_ordy   [2];
  logic                   c_irdy   [2];
  logic                   c_acc    [2];
  logic                   c_err    [2];
  logic [NUM_SLAVES-1:0]  dec_slv  [2];
  logic [1:0]             dec_err  [2];
  logic                   ov_q     [2];
  logic                   ov_d     [2];
  logic [NUM_SLAVES-1:0]  os_q     [2];
  logic [NUM_SLAVES-1:0]  os_d     [2];
  logic [1:0]             oe_q     [2];
  logic [1:0]             oe_d     [2];

  // Error status
  logic                   ev_q, ev_d;
  logic [ADDR_WIDTH-1:0]  ea_q, ea_d;
  logic [MW-1:0]          em_q, em_d;
  logic [1:0]             ec_q, ec_d;
  logic                   ew_q, ew_d;
  logic [15:0]            cnt_q, cnt_d;

  assign c_addr[0] = aw.in_addr;
  assign c_addr[1] = ar.in_addr;
  assign c_prot[0] = aw.in_prot;
  assign c_prot[1] = ar.in_prot;
  assign c_mst[0]  = aw.in_master;
  assign c_mst[1]  = ar.in_master;
  assign c_ivld[0] = aw.in_valid;
  assign c_ivld[1] = ar.in_valid;
  assign c_ordy[0] = aw.out_ready;
  assign c_ordy[1] = ar.out_ready;

  assign aw.in_ready  = c_irdy[0];
  assign ar.in_ready  = c_irdy[1];
  assign aw.out_valid = ov_q[0];
  assign ar.out_valid = ov_q[1];
  assign aw.out_slave = os_q[0];
  assign ar.out_slave = os_q[1];
  assign aw.out_err   = oe_q[0];
  assign ar.out_err   = oe_q[1];

  assign locked       = locked_q;
  assign err_valid    = ev_q;
  assign err_addr     = ea_q;
  assign err_master   = em_q;
  assign err_code     = ec_q;
  assign err_is_write = ew_q;
  assign err_count    = cnt_q;

  // Table update
  always_comb begin
    en_d     = en_q;
    base_d   = base_q;
    limit_d  = limit_q;
    slv_d    = slv_q;
    mmask_d  = mmask_q;
    pmask_d  = pmask_q;
    pval_d   = pval_q;
    locked_d = locked_q | cfg_lock;
    if (cfg_we && !locked_q) begin
      en_d[cfg_idx]    = cfg_en;
      base_d[cfg_idx]  = cfg_base;
      limit_d[cfg_idx] = cfg_limit;
      slv_d[cfg_idx]   = cfg_slave;
      mmask_d[cfg_idx] = cfg_mmask;
      pmask_d[cfg_idx] = cfg_prot_mask;
      pval_d[cfg_idx]  = cfg_prot_val;
    end
  end

  // Decode and output stage, per channel
  always_comb begin
    logic          hit;
    logic [RW-1:0] win;
    for (int c = 0; c < 2; c++) begin
      hit = 1'b0;
      win = '0;
      // Descending scan so the lowest matching index wins
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
        if (en_q[r] &&
            c_addr[c] >= base_q[r] &&
            c_addr[c] <= limit_q[r] &&
            {{(32-SW){1'b0}}, slv_q[r]} < NUM_SLAVES) begin
          hit = 1'b1;
          win = RW'(r);
        end
      end
      dec_slv[c] = '0;
      dec_err[c] = 2'd1;
      if (hit) begin
        if (!mmask_q[win][c_mst[c]]) begin
          dec_err[c] = 2'd2;
        end else if ((c_prot[c] & pmask_q[win]) !=
                     (pval_q[win] & pmask_q[win])) begin
          dec_err[c] = 2'd3;
        end else begin
          dec_err[c] = 2'd0;
          dec_slv[c] = {{(NUM_SLAVES-1){1'b0}}, 1'b1}
                       << slv_q[win];
        end
      end
      c_irdy[c] = !areset && (!ov_q[c] || c_ordy[c]);
      c_acc[c]  = c_ivld[c] && c_irdy[c];
      c_err[c]  = c_acc[c] && (dec_err[c] != 2'd0);
      ov_d[c]   = ov_q[c] && !c_ordy[c];
      os_d[c]   = os_q[c];
      oe_d[c]   = oe_q[c];
      if (c_acc[c]) begin
        ov_d[c] = 1'b1;
        os_d[c] = dec_slv[c];
        oe_d[c] = dec_err[c];
      end
    end
  end

  // Error capture; a clear in the same cycle acts before new errors
  always_comb begin
    logic [16:0] sum;
    logic        vbase;
    vbase = ev_q && !err_clear;
    sum   = {1'b0, (err_clear ? 16'd0 : cnt_q)}
            + 17'(c_err[0]) + 17'(c_err[1]);
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    ev_d  = vbase;
    ea_d  = ea_q;
    em_d  = em_q;
    ec_d  = ec_q;
    ew_d  = ew_q;
    if (!vbase && (c_err[0] || c_err[1])) begin
      ev_d = 1'b1;
      ew_d = c_err[0];
      if (c_err[0]) begin
        ea_d = c_addr[0];
        em_d = c_mst[0];
        ec_d = dec_err[0];
      end else begin
        ea_d = c_addr[1];
        em_d = c_mst[1];
        ec_d = dec_err[1];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int r = 0; r < NUM_REGIONS; r++) begin
        en_q[r]    <= 1'b0;
        base_q[r]  <= '0;
        limit_q[r] <= '0;
        slv_q[r]   <= '0;
        mmask_q[r] <= '0;
        pmask_q[r] <= '0;
        pval_q[r]  <= '0;
      end
      for (int c = 0; c < 2; c++) begin
        ov_q[c] <= 1'b0;
        os_q[c] <= '0;
        oe_q[c] <= '0;
      end
      locked_q <= 1'b0;
      ev_q     <= 1'b0;
      ea_q     <= '0;
      em_q     <= '0;
      ec_q     <= '0;
      ew_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      en_q     <= en_d;
      base_q   <= base_d;
      limit_q  <= limit_d;
      slv_q    <= slv_d;
      mmask_q  <= mmask_d;
      pmask_q  <= pmask_d;
      pval_q   <= pval_d;
      ov_q     <= ov_d;
      os_q     <= os_d;
      oe_q     <= oe_d;
      locked_q <= locked_d;
      ev_q     <= ev_d;
      ea_q     <= ea_d;
      em_q     <= em_d;
      ec_q     <= ec_d;
      ew_q     <= ew_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi4_region_decoder.sv
// Directed bench for axi4_region_decoder.
// Table-driven decode vectors plus hand sequences for status and stalls.
module tb_axi4_region_decoder;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [39:0] cfg_base;
  logic [39:0] cfg_limit;
  logic [2:0]  cfg_slave;
  logic [7:0]  cfg_mmask;
  logic [2:0]  cfg_prot_mask;
  logic [2:0]  cfg_prot_val;
  logic        cfg_en;
  logic        cfg_lock;
  logic        locked;
  logic        err_clear;
  logic        err_valid;
  logic [39:0] err_addr;
  logic [2:0]  err_master;
  logic [1:0]  err_code;
  logic        err_is_write;
  logic [15:0] err_count;

  int tests = 0;
  int fails = 0;

  always #5 aclk = ~aclk;

  axi4_region_decoder_if #(.ADDR_WIDTH(40), .NUM_SLAVES(8), .MW(3)) aw_if ();
  axi4_region_decoder_if #(.ADDR_WIDTH(40), .NUM_SLAVES(8), .MW(3)) ar_if ();

  axi4_region_decoder dut (
    .aclk(aclk), .areset(areset),
    .aw(aw_if), .ar(ar_if),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_base(cfg_base), .cfg_limit(cfg_limit),
    .cfg_slave(cfg_slave), .cfg_mmask(cfg_mmask),
    .cfg_prot_mask(cfg_prot_mask), .cfg_prot_val(cfg_prot_val),
    .cfg_en(cfg_en), .cfg_lock(cfg_lock), .locked(locked),
    .err_clear(err_clear), .err_valid(err_valid),
    .err_addr(err_addr), .err_master(err_master),
    .err_code(err_code), .err_is_write(err_is_write),
    .err_count(err_count)
  );

  typedef struct {
    logic        is_ar;
    logic [39:0] addr;
    logic [2:0]  prot;
    logic [2:0]  mst;
    logic [7:0]  slv;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic ch, input logic v, input logic [39:0] a,
                       input logic [2:0] p, input logic [2:0] m);
    if (ch) begin
      ar_if.in_valid = v; ar_if.in_addr = a;
      ar_if.in_prot = p;  ar_if.in_master = m;
    end else begin
      aw_if.in_valid = v; aw_if.in_addr = a;
      aw_if.in_prot = p;  aw_if.in_master = m;
    end
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [39:0] b,
                     input logic [39:0] l, input logic [2:0] s,
                     input logic [7:0] mm, input logic [2:0] pm,
                     input logic [2:0] pv, input logic en);
    @(negedge aclk);
    cfg_we = 1'b1; cfg_idx = idx; cfg_base = b; cfg_limit = l;
    cfg_slave = s; cfg_mmask = mm; cfg_prot_mask = pm;
    cfg_prot_val = pv; cfg_en = en;
    @(negedge aclk);
    cfg_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    @(negedge aclk);
    drive(v.is_ar, 1'b1, v.addr, v.prot, v.mst);
    #1;
    check({nm, " in_ready"},
          v.is_ar ? ar_if.in_ready : aw_if.in_ready, 1);
    @(negedge aclk);
    if (v.is_ar) begin
      check({nm, " valid"}, ar_if.out_valid, 1);
      check({nm, " slave"}, ar_if.out_slave, v.slv);
      check({nm, " err"}, ar_if.out_err, v.err);
    end else begin
      check({nm, " valid"}, aw_if.out_valid, 1);
      check({nm, " slave"}, aw_if.out_slave, v.slv);
      check({nm, " err"}, aw_if.out_err, v.err);
    end
    drive(v.is_ar, 1'b0, '0, '0, '0);
  endtask

  task automatic pulse_clear();
    @(negedge aclk);
    err_clear = 1'b1;
    @(negedge aclk);
    err_clear = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0, 40'h01_0000_0000, 3'b000, 3'd0, 8'h01, 2'd0};
    vecs[1]  = '{1, 40'h04_0000_1000, 3'b000, 3'd1, 8'h04, 2'd0};
    vecs[2]  = '{1, 40'h04_1000_0000, 3'b000, 3'd1, 8'h20, 2'd0};
    vecs[3]  = '{0, 40'h01_FFFF_FFFF, 3'b000, 3'd3, 8'h01, 2'd0};
    vecs[4]  = '{0, 40'h02_0000_0000, 3'b000, 3'd3, 8'h00, 2'd1};
    vecs[5]  = '{1, 40'h04_00FF_FFFF, 3'b000, 3'd0, 8'h04, 2'd0};
    vecs[6]  = '{1, 40'h04_0100_0000, 3'b000, 3'd0, 8'h20, 2'd0};
    vecs[7]  = '{0, 40'h0A_0000_0000, 3'b000, 3'd0, 8'h02, 2'd0};
    vecs[8]  = '{0, 40'h0A_0000_0000, 3'b000, 3'd1, 8'h00, 2'd2};
    vecs[9]  = '{1, 40'h08_0000_0000, 3'b011, 3'd0, 8'h00, 2'd3};
    vecs[10] = '{1, 40'h08_0000_0000, 3'b001, 3'd0, 8'h40, 2'd0};
    vecs[11] = '{1, 40'h08_0000_0000, 3'b101, 3'd0, 8'h40, 2'd0};
    vecs[12] = '{0, 40'h00_0000_0000, 3'b000, 3'd7, 8'h01, 2'd0};

    areset = 1'b1;
    cfg_we = 0; cfg_idx = 0; cfg_base = 0; cfg_limit = 0;
    cfg_slave = 0; cfg_mmask = 0; cfg_prot_mask = 0;
    cfg_prot_val = 0; cfg_en = 0; cfg_lock = 0; err_clear = 0;
    drive(0, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0);
    aw_if.out_ready = 1'b1;
    ar_if.out_ready = 1'b1;

    repeat (3) @(negedge aclk);
    check("rst aw in_ready", aw_if.in_ready, 0);
    check("rst ar in_ready", ar_if.in_ready, 0);
    areset = 1'b0;
    @(negedge aclk);
    check("rst aw in_ready 1", aw_if.in_ready, 1);
    check("rst ar in_ready 1", ar_if.in_ready, 1);
    check("rst aw out_valid", aw_if.out_valid, 0);
    check("rst aw slave", aw_if.out_slave, 0);
    check("rst ar err", ar_if.out_err, 0);
    check("rst locked", locked, 0);
    check("rst err_valid", err_valid, 0);
    check("rst err_count", err_count, 0);
    check("rst err_addr", err_addr, 0);

    cfg(0, 40'h00_0000_0000, 40'h01_FFFF_FFFF, 0, 8'hFF, 0, 0, 1);
    cfg(1, 40'h04_0000_0000, 40'h04_00FF_FFFF, 2, 8'hFF, 0, 0, 1);
    cfg(2, 40'h0A_0000_0000, 40'h0A_0000_FFFF, 1, 8'h01, 0, 0, 1);
    cfg(3, 40'h04_0000_0000, 40'h04_FFFF_FFFF, 5, 8'hFF, 0, 0, 1);
    cfg(4, 40'h08_0000_0000, 40'h08_FFFF_FFFF, 6, 8'hFF,
        3'b011, 3'b001, 1);
    cfg(5, 40'h09_0000_0000, 40'h09_FFFF_FFFF, 7, 8'h00, 0, 0, 1);

    for (int i = 0; i < 13; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    @(negedge aclk);
    check("tbl err_count", err_count, 3);
    check("tbl err_valid", err_valid, 1);
    check("tbl err_addr", err_addr, 40'h02_0000_0000);
    check("tbl err_master", err_master, 3);
    check("tbl err_code", err_code, 1);
    check("tbl err_is_write", err_is_write, 1);

    // Write and request on the same edge: request sees the old table
    cfg_we = 1'b1; cfg_idx = 6; cfg_base = 40'h0B_0000_0000;
    cfg_limit = 40'h0B_FFFF_FFFF; cfg_slave = 3; cfg_mmask = 8'hFF;
    cfg_prot_mask = 0; cfg_prot_val = 0; cfg_en = 1;
    drive(0, 1, 40'h0B_0000_0000, 0, 0);
    @(negedge aclk);
    cfg_we = 1'b0;
    check("wr-edge old err", aw_if.out_err, 1);
    @(negedge aclk);
    check("wr-edge new slave", aw_if.out_slave, 8'h08);
    check("wr-edge new err", aw_if.out_err, 0);
    drive(0, 0, '0, '0, '0);
    check("wr-edge count", err_count, 4);

    pulse_clear();
    check("clr err_valid", err_valid, 0);
    check("clr err_count", err_count, 0);

    run_vec('{1, 40'h08_0000_0000, 3'b011, 3'd4, 8'h00, 2'd3}, "prot");
    check("prot count", err_count, 1);
    check("prot code", err_code, 3);
    check("prot is_write", err_is_write, 0);
    run_vec('{1, 40'h08_0000_0000, 3'b001, 3'd4, 8'h40, 2'd0}, "prot ok");

    pulse_clear();
    @(negedge aclk);
    drive(0, 1, 40'hFF_0000_0000, 0, 2);
    drive(1, 1, 40'h09_0000_0000, 0, 5);
    @(negedge aclk);
    drive(0, 0, '0, '0, '0);
    drive(1, 0, '0, '0, '0);
    check("dual aw err", aw_if.out_err, 1);
    check("dual ar err", ar_if.out_err, 2);
    check("dual count", err_count, 2);
    check("dual valid", err_valid, 1);
    check("dual is_write", err_is_write, 1);
    check("dual master", err_master, 2);
    check("dual code", err_code, 1);
    check("dual addr", err_addr, 40'hFF_0000_0000);

    // Clear and a new error together: count restarts at 1, capture re-arms
    @(negedge aclk);
    err_clear = 1'b1;
    drive(1, 1, 40'h09_0000_0000, 0, 5);
    @(negedge aclk);
    err_clear = 1'b0;
    drive(1, 0, '0, '0, '0);
    check("clr+err count", err_count, 1);
    check("clr+err valid", err_valid, 1);
    check("clr+err is_write", err_is_write, 0);
    check("clr+err code", err_code, 2);
    check("clr+err master", err_master, 5);

    @(negedge aclk);
    cfg_lock = 1'b1;
    @(negedge aclk);
    cfg_lock = 1'b0;
    check("locked", locked, 1);
    cfg(0, 0, 0, 0, 0, 0, 0, 0);
    check("locked held", locked, 1);
    run_vec('{0, 40'h01_0000_0000, 3'b000, 3'd0, 8'h01, 2'd0}, "lock");

    // Backpressure on AW
    @(negedge aclk);
    aw_if.out_ready = 1'b0;
    drive(0, 1, 40'h00_0000_1000, 0, 0);
    @(negedge aclk);
    check("bp r1 valid", aw_if.out_valid, 1);
    check("bp r1 slave", aw_if.out_slave, 8'h01);
    drive(0, 1, 40'h0A_0000_0000, 0, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge aclk);
      check($sformatf("bp hold%0d slave", k), aw_if.out_slave, 8'h01);
      check($sformatf("bp hold%0d in_ready", k), aw_if.in_ready, 0);
    end
    aw_if.out_ready = 1'b1;
    @(negedge aclk);
    check("bp r2 valid", aw_if.out_valid, 1);
    check("bp r2 slave", aw_if.out_slave, 8'h02);
    drive(0, 1, 40'h04_0000_0000, 0, 0);
    @(negedge aclk);
    check("bp r3 valid", aw_if.out_valid, 1);
    check("bp r3 slave", aw_if.out_slave, 8'h04);
    drive(0, 0, '0, '0, '0);
    @(negedge aclk);
    check("bp drained", aw_if.out_valid, 0);

    // Reset during a stall
    aw_if.out_ready = 1'b0;
    drive(0, 1, 40'h00_0000_0000, 0, 0);
    @(negedge aclk);
    drive(0, 0, '0, '0, '0);
    check("rst2 pre valid", aw_if.out_valid, 1);
    areset = 1'b1;
    #1;
    check("rst2 in_ready low", aw_if.in_ready, 0);
    @(negedge aclk);
    check("rst2 out_valid", aw_if.out_valid, 0);
    check("rst2 slave", aw_if.out_slave, 0);
    check("rst2 err", aw_if.out_err, 0);
    check("rst2 locked", locked, 0);
    check("rst2 err_valid", err_valid, 0);
    check("rst2 err_count", err_count, 0);
    check("rst2 err_code", err_code, 0);
    areset = 1'b0;
    aw_if.out_ready = 1'b1;
    #1;
    check("rst2 in_ready", aw_if.in_ready, 1);
    run_vec('{0, 40'h01_0000_0000, 3'b000, 3'd0, 8'h00, 2'd1}, "rst2 tbl");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
